updn_counter_driver: RTL
========================

// Module: updn_counter_driver
// PURPOSE
//  Command sequencer on the control side of the 5-bit up/down counter: drives its Up/Down/Load/IN
//  inputs, watches Counter/High/Low. Accepts LOAD / COUNT_UP_TO / COUNT_DOWN_TO / SWEEP over valid/ready.
//  Steps the counter one unit per STEP_CYCLES clocks, checks that every step lands. Reports Done/Err.
// PARAMETERS
//  WIDTH        5  counter width; Cmd_Arg, IN and Counter are all WIDTH bits
//  STEP_CYCLES  2  clocks per step, >=2: 1 pulse cycle plus >=1 settle cycle before Counter is checked
// PORTS
//  CLK        in   1      clock, rising edge
//  RST_n      in   1      synchronous active-low reset
//  Cmd_Valid  in   1      command present
//  Cmd_Ready  out  1      driver can accept a command (IDLE only)
//  Cmd_Op     in   2      00 LOAD, 01 COUNT_UP_TO, 10 COUNT_DOWN_TO, 11 SWEEP
//  Cmd_Arg    in   WIDTH  load value or target
//  Abort      in   1      cancel the active command
//  Up         out  1      counter increment request, one-cycle pulse
//  Down       out  1      counter decrement request, one-cycle pulse
//  Load       out  1      counter load strobe, one-cycle pulse
//  IN         out  WIDTH  counter load value
//  Counter    in   WIDTH  current counter value
//  High       in   1      counter == all-ones
//  Low        in   1      counter == 0
//  Busy       out  1      command in progress
//  Done       out  1      one-cycle pulse, command finished
//  Err        out  1      valid only with Done; command failed
// BEHAVIOUR
//  Reset: RST_n=0 sampled at CLK -> state IDLE. Up=Down=Load=Busy=Done=Err=0, IN=0, Cmd_Ready=1.
//    Mid-command reset drops the command and sends no Done.
//  Handshake: accept on Cmd_Valid&&Cmd_Ready. Cmd_Op/Cmd_Arg are latched. Cmd_Ready=0 and Busy=1 from the next cycle to Done.
//  Output exclusivity: at most one of Up/Down/Load is high in any cycle. Each is a one-cycle pulse.
//  FSM states: IDLE, LOAD, CHECK, STEP, SETTLE, SWEEP_UP, SWEEP_DN, FINISH.
//  LOAD: Load=1 and IN=arg for 1 cycle. Next cycle CHECK compares Counter with arg.
//    FINISH then pulses Done; Err=1 on mismatch. Done arrives 3 cycles after accept.
//  COUNT_UP_TO: first cycle after accept, compare Counter with arg.
//    Counter==arg -> Done, Err=0, no steps. Counter>arg -> Done, Err=1.
//    Otherwise: Up pulse (STEP), STEP_CYCLES-1 settle cycles, then compare. Repeat until Counter==arg.
//  COUNT_DOWN_TO: mirror of COUNT_UP_TO using Down. Counter<arg -> Err.
//  SWEEP: step up until High=1, then step down until Low=1, then Done, Err=0. arg is ignored.
//    Starting at High: skip to down phase. Starting at Low: full triangle.
//  Step check: after settle, Counter must equal prev+1 (or prev-1). Otherwise Done+Err; counter is left as-is.
//  Never issue Up while High=1 or Down while Low=1. Saturation is a sequencing bug -> Err.
//  Abort in any non-IDLE state: no further pulses. Next cycle Done=1, Err=1, then IDLE.
//    An in-flight pulse is not retracted. Abort in IDLE is ignored.
//  Arithmetic: prev+1 / prev-1 are computed in WIDTH bits. Wrap cannot occur because of the High/Low guards.
// CONFIGURATION
//  UPDN_SWEEP_EN defined: SWEEP op behaves as above.
//  UPDN_SWEEP_EN undefined: op 11 is accepted, followed by Done+Err on the next cycle with no counter pulses.
//    SWEEP_UP/SWEEP_DN are not synthesised.
// STRUCTURE
//  Package updn_pkg: op encodings (OP_LOAD, OP_UP_TO, OP_DN_TO, OP_SWEEP) and the FSM state typedef.
//  Sub-module updn_step_timer: down-counter from STEP_CYCLES-1, start/expired handshake, reset to idle.
//  FSM, latched arg/op and prev-value register stay in updn_counter_driver.
// TESTING (WIDTH=5, STEP_CYCLES=2, driver wired to the real counter)
//  1 Reset held 2 cycles, then LOAD 5'd17 -> Load high 1 cycle with IN=17; Counter=17; Done 3 cycles after accept, Err=0.
//  2 Counter=3, COUNT_UP_TO 7 -> exactly 4 Up pulses, 2 cycles apart; Done with Counter=7, Err=0.
//    COUNT_UP_TO 2 from 7 -> Done+Err, no pulses.
//  3 Counter=0, SWEEP -> 31 Up pulses then 31 Down pulses; Done with Counter=0, Err=0; Up never high while High=1.
//  4 Counter frozen by a stub (never changes), COUNT_DOWN_TO 0 from 9 -> first check fails; Done+Err after 1 Down pulse.
//  5 Abort during COUNT_UP_TO 0->20 at Counter=6 -> no more pulses; Done+Err next cycle; Cmd_Ready=1 after.
//    RST_n low mid-sweep -> IDLE with all outputs 0 and no Done.
//  6 Build without UPDN_SWEEP_EN: op 11 -> Done+Err 1 cycle after accept, zero Up/Down/Load pulses.

Source files
------------

// File: rtl/updn_pkg.sv
// Shared op encodings and FSM state type for the up/down counter driver.
package updn_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP_TO = 2'b01;
  localparam logic [1:0] OP_DN_TO = 2'b10;
  localparam logic [1:0] OP_SWEEP = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StStep,
    StSettle,
    StSweepUp,
    StSweepDn,
    StFinish
  } state_e;

endpackage

// File: rtl/updn_step_timer.sv
// Settle timer: started on the step-pulse cycle, flags the last settle cycle
// StepCycles-1 cycles later. Synchronous active-low reset returns it to idle.
module updn_step_timer #(
  parameter int unsigned StepCycles = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(StepCycles) + 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            active_q, active_d;

  // Next-state: clear wins over start; count down while active.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (clear_i) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (start_i) begin
      cnt_d    = CntW'(StepCycles - 1);
      active_d = 1'b1;
    end else if (active_q) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CntW'(1)) begin
        active_d = 1'b0;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign expired_o = active_q && (cnt_q == CntW'(1));

endmodule

// File: rtl/updn_counter_driver.sv
// Command sequencer driving a WIDTH-bit up/down counter (Up/Down/Load/IN) and
// checking that every step lands. Optional SWEEP op enabled by UPDN_SWEEP_EN;
// without it op 11 finishes at once with Err.
module updn_counter_driver
  import updn_pkg::*;
#(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned STEP_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic [1:0]       Cmd_Op,
  input  logic [WIDTH-1:0] Cmd_Arg,
  input  logic             Abort,
  output logic             Up,
  output logic             Down,
  output logic             Load,
  output logic [WIDTH-1:0] IN,
  input  logic [WIDTH-1:0] Counter,
  input  logic             High,
  input  logic             Low,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             dir_q, dir_d;   // 1: last step was up
  logic             err_q, err_d;

  logic             timer_start, timer_clear, timer_expired;
  logic [WIDTH-1:0] expect_next;
  logic             wrong_dir;
  logic             going_up;
  logic             abort_take;

  updn_step_timer #(
    .StepCycles(STEP_CYCLES)
  ) u_step_timer (
    .clk_i    (CLK),
    .rst_ni   (RST_n),
    .start_i  (timer_start),
    .clear_i  (timer_clear),
    .expired_o(timer_expired)
  );

  // Next-state and pulse outputs; abort overrides everything at the end.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    arg_d       = arg_q;
    prev_d      = prev_q;
    dir_d       = dir_q;
    err_d       = err_q;
    Up          = 1'b0;
    Down        = 1'b0;
    Load        = 1'b0;
    timer_start = 1'b0;
    timer_clear = 1'b0;

    expect_next = dir_q ? (prev_q + WIDTH'(1)) : (prev_q - WIDTH'(1));
    going_up    = (op_q == OP_UP_TO);
    wrong_dir   = going_up ? (Counter > arg_q) : (Counter < arg_q);
    abort_take  = Abort && (state_q != StIdle) && (state_q != StFinish);

    unique case (state_q)
      StIdle: begin
        if (Cmd_Valid) begin
          op_d  = Cmd_Op;
          arg_d = Cmd_Arg;
          err_d = 1'b0;
          if (Cmd_Op == OP_LOAD) begin
            state_d = StLoad;
          end else if (Cmd_Op == OP_SWEEP) begin
`ifdef UPDN_SWEEP_EN
            state_d = StSweepUp;
`else
            state_d = StFinish;
            err_d   = 1'b1;
`endif
          end else begin
            state_d = StCheck;
          end
        end
      end

      StLoad: begin
        Load    = 1'b1;
        state_d = StCheck;
      end

      StCheck: begin
        if (op_q == OP_LOAD) begin
          err_d   = (Counter != arg_q);
          state_d = StFinish;
        end else if (Counter == arg_q) begin
          state_d = StFinish;
        end else if (wrong_dir) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end else begin
          state_d = StStep;
        end
      end

      StStep: begin
        // Saturated counter means the sequence is broken; never pulse into it.
        if (going_up ? High : Low) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end else begin
          Up          = going_up;
          Down        = !going_up;
          dir_d       = going_up;
          prev_d      = Counter;
          timer_start = 1'b1;
          state_d     = StSettle;
        end
      end

      StSettle: begin
        if (timer_expired) begin
          if (Counter != expect_next) begin
            err_d   = 1'b1;
            state_d = StFinish;
          end else if (op_q == OP_SWEEP) begin
`ifdef UPDN_SWEEP_EN
            state_d = dir_q ? StSweepUp : StSweepDn;
`else
            err_d   = 1'b1;
            state_d = StFinish;
`endif
          end else if (Counter == arg_q) begin
            state_d = StFinish;
          end else begin
            state_d = StStep;
          end
        end
      end

`ifdef UPDN_SWEEP_EN
      StSweepUp: begin
        if (High) begin
          state_d = StSweepDn;
        end else begin
          Up          = 1'b1;
          dir_d       = 1'b1;
          prev_d      = Counter;
          timer_start = 1'b1;
          state_d     = StSettle;
        end
      end

      StSweepDn: begin
        if (Low) begin
          state_d = StFinish;
        end else begin
          Down        = 1'b1;
          dir_d       = 1'b0;
          prev_d      = Counter;
          timer_start = 1'b1;
          state_d     = StSettle;
        end
      end
`endif

      StFinish: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort_take) begin
      Up          = 1'b0;
      Down        = 1'b0;
      Load        = 1'b0;
      timer_start = 1'b0;
      timer_clear = 1'b1;
      err_d       = 1'b1;
      state_d     = StFinish;
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    Cmd_Ready = (state_q == StIdle);
    Busy      = (state_q != StIdle);
    Done      = (state_q == StFinish);
    Err       = (state_q == StFinish) && err_q;
    IN        = (state_q == StLoad) ? arg_q : '0;
  end

  // State and command registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q <= StIdle;
      op_q    <= OP_LOAD;
      arg_q   <= '0;
      prev_q  <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      prev_q  <= prev_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

endmodule
